// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared core types: FU kinds, CDB broadcast and CDB holding-slot structs
package rv32i_types;

    localparam int CDB_DATA_W    = 32;
    localparam int CDB_ROB_IDX_W = 5;
    localparam int CDB_REG_IDX_W = 5;
    localparam int NUM_CDB_FU    = 4;

    typedef enum logic [2:0] {
        TYPE_NONE = 3'd0,
        TYPE_ALU  = 3'd1,
        TYPE_MUL  = 3'd2,
        TYPE_BR   = 3'd3,
        TYPE_MEM  = 3'd4
    } types_t;

    typedef struct packed {
        logic                     valid;
        logic [CDB_DATA_W-1:0]    data;
        logic [CDB_ROB_IDX_W-1:0] rob_idx;
        logic [CDB_REG_IDX_W-1:0] rd_addr;
        logic                     regf_we;
        logic [CDB_DATA_W-1:0]    commit_data;
        logic [CDB_ROB_IDX_W-1:0] commit_rob_idx;
        logic [CDB_REG_IDX_W-1:0] commit_rd_addr;
    } cdb_t;

    typedef struct packed {
        logic                     valid;
        logic [CDB_DATA_W-1:0]    data;
        logic [CDB_ROB_IDX_W-1:0] rob_idx;
        logic [CDB_REG_IDX_W-1:0] rd_addr;
        logic                     regf_we;
    } cdb_req_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - per-FU result handoff bundle into the CDB arbiter
interface cdb_arbiter_if #(
    parameter int NUM_FU    = 4,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5,
    parameter int REG_IDX_W = 5
);
    logic [NUM_FU-1:0]           fu_valid;
    logic [NUM_FU-1:0]           fu_ready;
    logic [NUM_FU*DATA_W-1:0]    fu_data;
    logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx;
    logic [NUM_FU*REG_IDX_W-1:0] fu_rd_addr;
    logic [NUM_FU-1:0]           fu_regf_we;

    modport master (
        output fu_valid, fu_data, fu_rob_idx, fu_rd_addr, fu_regf_we,
        input  fu_ready
    );

    modport slave (
        input  fu_valid, fu_data, fu_rob_idx, fu_rd_addr, fu_regf_we,
        output fu_ready
    );
endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational round-robin picker, scans upward from rr_ptr with wrap
module rr_arbiter #(
    parameter int NUM_FU = 4,
    parameter int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic [NUM_FU-1:0] req_i,
    input  logic [PTR_W-1:0]  rr_ptr_i,
    output logic [NUM_FU-1:0] grant_o,
    output logic [PTR_W-1:0]  winner_o
);
    int   idx;
    logic found;

    always_comb begin
        grant_o  = '0;
        winner_o = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr_i) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = idx[PTR_W-1:0];
            end
        end
    end
endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - CDB sharing: per-FU holding slots, round-robin grant, registered broadcast
// Optional per-FU stall counters when CDB_STALL_CNT_EN is defined.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU    = NUM_CDB_FU,
    parameter int DATA_W    = CDB_DATA_W,
    parameter int ROB_IDX_W = CDB_ROB_IDX_W,
    parameter int REG_IDX_W = CDB_REG_IDX_W,
    parameter int PTR_W     = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    cdb_arbiter_if.slave         fu,
    input  logic                 rob_commit_valid,
    input  logic [DATA_W-1:0]    rob_commit_data,
    input  logic [ROB_IDX_W-1:0] rob_commit_rob_idx,
    input  logic [REG_IDX_W-1:0] rob_commit_rd_addr,
`ifdef CDB_STALL_CNT_EN
    output logic [NUM_FU*32-1:0] stall_cnt,
`endif
    output cdb_t                 cdb_out,
    output logic [PTR_W-1:0]     grant_idx
);
    cdb_req_t          hold_q [NUM_FU];
    cdb_req_t          hold_d [NUM_FU];
    logic [NUM_FU-1:0] req;
    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] ready;
    logic [PTR_W-1:0]  winner;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  grant_idx_q, grant_idx_d;
    cdb_t              cdb_q, cdb_d;
    logic              win;

    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_FU; i++) req[i] = hold_q[i].valid;
    end

    rr_arbiter #(.NUM_FU(NUM_FU), .PTR_W(PTR_W)) u_rr (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (grant),
        .winner_o (winner)
    );

    // A slot being drained this cycle can refill in the same cycle.
    assign ready       = ~req | grant;
    assign fu.fu_ready = ready;
    assign win         = |grant && !flush;

    always_comb begin
        hold_d = hold_q;
        for (int i = 0; i < NUM_FU; i++) begin
            if (flush) begin
                hold_d[i].valid = 1'b0;
            end else if (fu.fu_valid[i] && ready[i]) begin
                hold_d[i].valid   = 1'b1;
                hold_d[i].data    = fu.fu_data[i*DATA_W +: DATA_W];
                hold_d[i].rob_idx = fu.fu_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
                hold_d[i].rd_addr = fu.fu_rd_addr[i*REG_IDX_W +: REG_IDX_W];
                hold_d[i].regf_we = fu.fu_regf_we[i];
            end else if (grant[i]) begin
                hold_d[i].valid = 1'b0;
            end
        end

        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        cdb_d       = cdb_q;
        cdb_d.valid = win;
        if (win) begin
            rr_ptr_d      = (winner == PTR_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;
            grant_idx_d   = winner;
            cdb_d.data    = hold_q[winner].data;
            cdb_d.rob_idx = hold_q[winner].rob_idx;
            cdb_d.rd_addr = hold_q[winner].rd_addr;
            cdb_d.regf_we = hold_q[winner].regf_we;
        end

        // Commit is in-order and non-speculative, so flush does not touch it.
        cdb_d.commit_data    = rob_commit_valid ? rob_commit_data    : '0;
        cdb_d.commit_rob_idx = rob_commit_valid ? rob_commit_rob_idx : '0;
        cdb_d.commit_rd_addr = rob_commit_valid ? rob_commit_rd_addr : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) hold_q[i] <= '0;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            cdb_q       <= '0;
        end else begin
            hold_q      <= hold_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            cdb_q       <= cdb_d;
        end
    end

    assign cdb_out   = cdb_q;
    assign grant_idx = grant_idx_q;

`ifdef CDB_STALL_CNT_EN
    logic [31:0] stall_q [NUM_FU];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) stall_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (req[i] && !grant[i] && !flush && stall_q[i] != 32'hFFFF_FFFF)
                    stall_q[i] <= stall_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int i = 0; i < NUM_FU; i++) stall_cnt[i*32 +: 32] = stall_q[i];
    end
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        rob_commit_valid;
    logic [31:0] rob_commit_data;
    logic [4:0]  rob_commit_rob_idx;
    logic [4:0]  rob_commit_rd_addr;
    cdb_t        cdb_out;
    logic [1:0]  grant_idx;
`ifdef CDB_STALL_CNT_EN
    logic [127:0] stall_cnt;
`endif

    int vectors     = 0;
    int miscompares = 0;

    cdb_arbiter_if #(.NUM_FU(4), .DATA_W(32), .ROB_IDX_W(5), .REG_IDX_W(5)) fu_if ();

    cdb_arbiter #(.NUM_FU(4), .DATA_W(32), .ROB_IDX_W(5), .REG_IDX_W(5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .flush              (flush),
        .fu                 (fu_if.slave),
        .rob_commit_valid   (rob_commit_valid),
        .rob_commit_data    (rob_commit_data),
        .rob_commit_rob_idx (rob_commit_rob_idx),
        .rob_commit_rd_addr (rob_commit_rd_addr),
`ifdef CDB_STALL_CNT_EN
        .stall_cnt          (stall_cnt),
`endif
        .cdb_out            (cdb_out),
        .grant_idx          (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fu(input int i, input logic [31:0] d, input logic [4:0] rob,
                          input logic [4:0] rd, input logic we);
        fu_if.fu_data[i*32 +: 32]  = d;
        fu_if.fu_rob_idx[i*5 +: 5] = rob;
        fu_if.fu_rd_addr[i*5 +: 5] = rd;
        fu_if.fu_regf_we[i]        = we;
    endtask

    initial begin
        rst_n              = 1'b0;
        flush              = 1'b0;
        rob_commit_valid   = 1'b0;
        rob_commit_data    = '0;
        rob_commit_rob_idx = '0;
        rob_commit_rd_addr = '0;
        fu_if.fu_valid     = 4'b1111;
        fu_if.fu_data      = '1;
        fu_if.fu_rob_idx   = '1;
        fu_if.fu_rd_addr   = '1;
        fu_if.fu_regf_we   = '1;

        // Reset held two cycles while every FU presents a result
        step();
        step();
        rst_n          = 1'b1;
        fu_if.fu_valid = 4'b0000;
        check("reset_cdb", 96'(cdb_out), 96'd0);
        check("reset_gidx", 96'(grant_idx), 96'd0);
        check("reset_ready", 96'(fu_if.fu_ready), 96'hF);

        // Single alu result, 2-cycle latency
        set_fu(0, 32'hDEAD_BEEF, 5'd3, 5'd7, 1'b1);
        fu_if.fu_valid = 4'b0001;
        check("single_ready_in", 96'(fu_if.fu_ready), 96'hF);
        step();
        fu_if.fu_valid = 4'b0000;
        check("single_n1_valid", 96'(cdb_out.valid), 96'd0);
        check("single_n1_ready", 96'(fu_if.fu_ready), 96'hF);
        step();
        check("single_valid", 96'(cdb_out.valid), 96'd1);
        check("single_data", 96'(cdb_out.data), 96'hDEAD_BEEF);
        check("single_rob", 96'(cdb_out.rob_idx), 96'd3);
        check("single_rd", 96'(cdb_out.rd_addr), 96'd7);
        check("single_we", 96'(cdb_out.regf_we), 96'd1);
        check("single_gidx", 96'(grant_idx), 96'd0);
        step();
        check("single_drop_valid", 96'(cdb_out.valid), 96'd0);
        check("single_hold_data", 96'(cdb_out.data), 96'hDEAD_BEEF);

        // Re-reset so rr_ptr starts at 0 for the contention case
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) set_fu(i, 32'h100 + i, 5'(i), 5'(i + 1), 1'b1);
        fu_if.fu_valid = 4'b1111;
        step();
        fu_if.fu_valid = 4'b0000;
        check("cont_c1_ready", 96'(fu_if.fu_ready), 96'b0001);
        step();
        check("cont_c2_rob", 96'(cdb_out.rob_idx), 96'd0);
        check("cont_c2_gidx", 96'(grant_idx), 96'd0);
        check("cont_c2_ready", 96'(fu_if.fu_ready), 96'b0011);
        step();
        check("cont_c3_rob", 96'(cdb_out.rob_idx), 96'd1);
        check("cont_c3_ready", 96'(fu_if.fu_ready), 96'b0111);
        step();
        check("cont_c4_rob", 96'(cdb_out.rob_idx), 96'd2);
        check("cont_c4_ready", 96'(fu_if.fu_ready), 96'b1111);
        step();
        check("cont_c5_valid", 96'(cdb_out.valid), 96'd1);
        check("cont_c5_rob", 96'(cdb_out.rob_idx), 96'd3);
        check("cont_c5_data", 96'(cdb_out.data), 96'h103);
        check("cont_c5_gidx", 96'(grant_idx), 96'd3);
        step();
        check("cont_c6_valid", 96'(cdb_out.valid), 96'd0);

        // mul streams one result per cycle, tags 10..15
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                set_fu(1, 32'h2000 + k, 5'(10 + k), 5'd2, 1'b1);
                fu_if.fu_valid = 4'b0010;
            end else begin
                fu_if.fu_valid = 4'b0000;
            end
            check("stream_ready", 96'(fu_if.fu_ready[1]), 96'd1);
            if (k >= 2) begin
                check("stream_valid", 96'(cdb_out.valid), 96'd1);
                check("stream_rob", 96'(cdb_out.rob_idx), 96'(10 + k - 2));
            end
            step();
        end
        step();

        // rr_ptr is now 2: fill alu and mem, flush in the cycle mem would win
        set_fu(0, 32'h55, 5'd20, 5'd1, 1'b1);
        set_fu(3, 32'h66, 5'd23, 5'd2, 1'b1);
        fu_if.fu_valid = 4'b1001;
        step();
        fu_if.fu_valid     = 4'b0000;
        flush              = 1'b1;
        rob_commit_valid   = 1'b1;
        rob_commit_data    = 32'd5;
        rob_commit_rob_idx = 5'd9;
        rob_commit_rd_addr = 5'd4;
        check("flush_pre_ready", 96'(fu_if.fu_ready), 96'b1110);
        step();
        flush            = 1'b0;
        rob_commit_valid = 1'b0;
        check("flush_valid", 96'(cdb_out.valid), 96'd0);
        check("flush_ready", 96'(fu_if.fu_ready), 96'hF);
        check("flush_commit_data", 96'(cdb_out.commit_data), 96'd5);
        check("flush_commit_rob", 96'(cdb_out.commit_rob_idx), 96'd9);
        check("flush_commit_rd", 96'(cdb_out.commit_rd_addr), 96'd4);
        for (int i = 0; i < 4; i++) set_fu(i, 32'h300 + i, 5'(24 + i), 5'd3, 1'b0);
        fu_if.fu_valid = 4'b1111;
        step();
        fu_if.fu_valid = 4'b0000;
        check("flush_commit_zero", 96'(cdb_out.commit_data), 96'd0);
        check("flush_after_valid", 96'(cdb_out.valid), 96'd0);
        step();
        check("ptr_kept_rob", 96'(cdb_out.rob_idx), 96'd26);
        check("ptr_kept_gidx", 96'(grant_idx), 96'd2);
        step();
        check("ptr_next_rob", 96'(cdb_out.rob_idx), 96'd27);
        step();
        check("ptr_wrap_rob", 96'(cdb_out.rob_idx), 96'd24);
        check("ptr_wrap_gidx", 96'(grant_idx), 96'd0);
        step();
        check("ptr_last_rob", 96'(cdb_out.rob_idx), 96'd25);
        step();

`ifdef CDB_STALL_CNT_EN
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_fu(2, 32'h77, 5'd5, 5'd5, 1'b1);
        set_fu(3, 32'h88, 5'd6, 5'd6, 1'b1);
        fu_if.fu_valid = 4'b1100;
        for (int k = 0; k < 10; k++) step();
        fu_if.fu_valid = 4'b0000;
        for (int k = 0; k < 4; k++) step();
        check("stall_alu", 96'(stall_cnt[31:0]), 96'd0);
        check("stall_br", 96'(stall_cnt[95:64]), 96'd5);
        check("stall_mem", 96'(stall_cnt[127:96]), 96'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
